// File: rtl/aclint_memory.sv
// aclint_memory: memory-mapped ACLINT slave holding MSIP, MTIMECMP, MTIME and the SETSSIP pulse.
// Build option: define ACLINT_SSWI_EN to map SETSSIP at offset 0x8000 and drive o_ssip_set.
package eei;
  typedef logic [63:0] Addr;
  localparam Addr MMAP_ACLINT_BEGIN = 64'h0000_0000_0200_0000;
endpackage

module aclint_memory #(
  parameter eei::Addr    BASE      = eei::MMAP_ACLINT_BEGIN,
  parameter int unsigned MTIME_DIV = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [63:0] i_addr,
  input  logic        i_wen,
  input  logic [63:0] i_wdata,
  input  logic [7:0]  i_wmask,
  output logic        o_rvalid,
  output logic [63:0] o_rdata,
  output logic        o_msip,
  output logic        o_mtip,
  output logic        o_ssip_set,
  output logic [63:0] o_mtime
);

  localparam logic [63:0] OFF_MSIP     = 64'h0000;
  localparam logic [63:0] OFF_MTIMECMP = 64'h4000;
  localparam logic [63:0] OFF_MTIME    = 64'h7FF8;
  localparam logic [15:0] PRESC_MAX    = 16'(MTIME_DIV - 1);

  logic        accept;
  logic        wr;
  logic [63:0] offset;
  logic [63:0] bmask;
  logic        sel_msip;
  logic        sel_mtimecmp;
  logic        sel_mtime;

  logic        msip_q,     msip_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic [63:0] mtime_q,    mtime_d;
  logic [15:0] presc_q,    presc_d;
  logic        rvalid_q;
  logic [63:0] rdata_q,    rdata_d;

  assign o_ready      = 1'b1;
  assign accept       = i_valid & o_ready;
  assign wr           = accept & i_wen;
  assign offset       = i_addr - BASE;
  assign sel_msip     = (offset == OFF_MSIP);
  assign sel_mtimecmp = (offset == OFF_MTIMECMP);
  assign sel_mtime    = (offset == OFF_MTIME);

  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    bmask = '0;
    for (int k = 0; k < 8; k++) bmask[8*k +: 8] = {8{i_wmask[k]}};
  end

  always_comb begin
    msip_d = msip_q;
    if (wr && sel_msip && i_wmask[0]) msip_d = i_wdata[0];
  end

  always_comb begin
    mtimecmp_d = mtimecmp_q;
    if (wr && sel_mtimecmp) mtimecmp_d = (mtimecmp_q & ~bmask) | (i_wdata & bmask);
  end

  // A bus write to MTIME beats the tick and restarts the prescaler.
  always_comb begin
    mtime_d = mtime_q;
    presc_d = presc_q;
    if (wr && sel_mtime) begin
      mtime_d = (mtime_q & ~bmask) | (i_wdata & bmask);
      presc_d = '0;
    end else if (presc_q == PRESC_MAX) begin
      mtime_d = mtime_q + 64'd1;
      presc_d = '0;
    end else begin
      presc_d = presc_q + 16'd1;
    end
  end

  always_comb begin
    rdata_d = '0;
    if (accept && !i_wen) begin
      if (sel_msip)          rdata_d = {63'b0, msip_q};
      else if (sel_mtimecmp) rdata_d = mtimecmp_q;
      else if (sel_mtime)    rdata_d = mtime_q;
    end
  end

  // NOTE: the synchronous reset lives inside the clocked block; all state uses non-blocking <=.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      msip_q     <= 1'b0;
      mtimecmp_q <= '1;
      mtime_q    <= '0;
      presc_q    <= '0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      msip_q     <= msip_d;
      mtimecmp_q <= mtimecmp_d;
      mtime_q    <= mtime_d;
      presc_q    <= presc_d;
      rvalid_q   <= accept;
      rdata_q    <= rdata_d;
    end
  end

`ifdef ACLINT_SSWI_EN
  localparam logic [63:0] OFF_SETSSIP = 64'h8000;
  logic ssip_q, ssip_d;

  assign ssip_d = wr & (offset == OFF_SETSSIP) & i_wmask[0] & i_wdata[0];

  always_ff @(posedge i_clk) begin
    if (i_rst) ssip_q <= 1'b0;
    else       ssip_q <= ssip_d;
  end

  assign o_ssip_set = ssip_q;
`else
  assign o_ssip_set = 1'b0;
`endif

  assign o_rvalid = rvalid_q;
  assign o_rdata  = rdata_q;
  assign o_msip   = msip_q;
  assign o_mtip   = (mtime_q >= mtimecmp_q);
  assign o_mtime  = mtime_q;

endmodule

// File: tb/tb_aclint_memory.sv
// tb_aclint_memory: drives an MTIME_DIV=1 and an MTIME_DIV=4 instance from one bus and
// compares both against a time-based model (mtime = load value + elapsed cycles / divider).
module tb_aclint_memory;

  localparam logic [63:0] BASE   = 64'h0200_0000;
  localparam logic [63:0] A_MSIP = BASE + 64'h0000;
  localparam logic [63:0] A_CMP  = BASE + 64'h4000;
  localparam logic [63:0] A_TIME = BASE + 64'h7FF8;
  localparam logic [63:0] A_SSIP = BASE + 64'h8000;
  localparam logic [63:0] A_UNM  = BASE + 64'h1234;
  localparam logic [63:0] ONES   = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        i_rst, i_valid, i_wen;
  logic [63:0] i_addr, i_wdata;
  logic [7:0]  i_wmask;
  logic        o_ready [2], o_rvalid [2], o_msip [2], o_mtip [2], o_ssip_set [2];
  logic [63:0] o_rdata [2], o_mtime [2];

  always #5 clk = ~clk;

  aclint_memory #(.BASE(BASE), .MTIME_DIV(1)) u_div1 (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready[0]),
    .i_addr(i_addr), .i_wen(i_wen), .i_wdata(i_wdata), .i_wmask(i_wmask),
    .o_rvalid(o_rvalid[0]), .o_rdata(o_rdata[0]), .o_msip(o_msip[0]), .o_mtip(o_mtip[0]),
    .o_ssip_set(o_ssip_set[0]), .o_mtime(o_mtime[0])
  );

  aclint_memory #(.BASE(BASE), .MTIME_DIV(4)) u_div4 (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready[1]),
    .i_addr(i_addr), .i_wen(i_wen), .i_wdata(i_wdata), .i_wmask(i_wmask),
    .o_rvalid(o_rvalid[1]), .o_rdata(o_rdata[1]), .o_msip(o_msip[1]), .o_mtip(o_mtip[1]),
    .o_ssip_set(o_ssip_set[1]), .o_mtime(o_mtime[1])
  );

  // Reference model state
  int unsigned     div_v [2];
  bit              m_msip, m_rvalid, m_ssip;
  logic [63:0]     m_cmp;
  logic [63:0]     m_base_val [2];
  longint unsigned m_base_edge [2];
  logic [63:0]     m_rdata [2];
  longint unsigned edge_n;
  int              n_vec, n_err;

  typedef struct {
    bit          v;
    bit          w;
    logic [63:0] a;
    logic [63:0] wd;
    logic [7:0]  wm;
    logic [63:0] exp_rdata;
    bit          exp_msip;
  } vec_t;

  vec_t tbl [12];

  function automatic logic [63:0] mtime_now(int d);
    return m_base_val[d] + 64'((edge_n - m_base_edge[d]) / longint'(div_v[d]));
  endfunction

  function automatic logic [63:0] expand(logic [7:0] wm);
    logic [63:0] bm;
    for (int k = 0; k < 8; k++) bm[8*k +: 8] = {8{wm[k]}};
    return bm;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic compare_all();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("ready[%0d]", d),  64'(o_ready[d]),    64'(1));
      check($sformatf("rvalid[%0d]", d), 64'(o_rvalid[d]),   64'(m_rvalid));
      check($sformatf("rdata[%0d]", d),  o_rdata[d],         m_rdata[d]);
      check($sformatf("msip[%0d]", d),   64'(o_msip[d]),     64'(m_msip));
      check($sformatf("mtime[%0d]", d),  o_mtime[d],         mtime_now(d));
      check($sformatf("mtip[%0d]", d),   64'(o_mtip[d]),     64'(mtime_now(d) >= m_cmp));
      check($sformatf("ssip[%0d]", d),   64'(o_ssip_set[d]), 64'(m_ssip));
    end
  endtask

  task automatic do_reset(bit v, bit w, logic [63:0] a, logic [63:0] wd, logic [7:0] wm);
    i_rst = 1'b1; i_valid = v; i_wen = w; i_addr = a; i_wdata = wd; i_wmask = wm;
    @(posedge clk);
    edge_n++;
    m_msip = 1'b0; m_cmp = ONES; m_rvalid = 1'b0; m_ssip = 1'b0;
    for (int d = 0; d < 2; d++) begin
      m_base_val[d] = '0; m_base_edge[d] = edge_n; m_rdata[d] = '0;
    end
    #1;
    i_rst = 1'b0; i_valid = 1'b0;
    compare_all();
  endtask

  task automatic step(bit v, bit w, logic [63:0] a, logic [63:0] wd, logic [7:0] wm);
    logic [63:0] off, bm;
    logic [63:0] cur [2];
    off = a - BASE;
    bm  = expand(wm);
    for (int d = 0; d < 2; d++) cur[d] = mtime_now(d);
    i_valid = v; i_wen = w; i_addr = a; i_wdata = wd; i_wmask = wm;
    @(posedge clk);
    edge_n++;
    m_rvalid = v;
    m_ssip   = 1'b0;
    for (int d = 0; d < 2; d++) begin
      m_rdata[d] = '0;
      if (v && !w) begin
        if (off == 64'h0000)      m_rdata[d] = {63'b0, m_msip};
        else if (off == 64'h4000) m_rdata[d] = m_cmp;
        else if (off == 64'h7FF8) m_rdata[d] = cur[d];
      end
    end
    if (v && w) begin
      if (off == 64'h0000 && wm[0]) m_msip = wd[0];
      if (off == 64'h4000) m_cmp = (m_cmp & ~bm) | (wd & bm);
      if (off == 64'h7FF8) begin
        for (int d = 0; d < 2; d++) begin
          m_base_val[d]  = (cur[d] & ~bm) | (wd & bm);
          m_base_edge[d] = edge_n;
        end
      end
`ifdef ACLINT_SSWI_EN
      if (off == 64'h8000 && wm[0] && wd[0]) m_ssip = 1'b1;
`endif
    end
    #1;
    i_valid = 1'b0;
    compare_all();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, '0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit          seen;
    bit          exp_pulse;
    logic [63:0] addrs [6];

    div_v[0] = 1; div_v[1] = 4;
    n_vec = 0; n_err = 0; edge_n = 0;
    i_rst = 1'b1; i_valid = 1'b0; i_wen = 1'b0; i_addr = '0; i_wdata = '0; i_wmask = '0;
`ifdef ACLINT_SSWI_EN
    exp_pulse = 1'b1;
`else
    exp_pulse = 1'b0;
`endif

    tbl[0]  = '{1, 1, A_MSIP, 64'h1,                   8'h01, 64'h0,                   1};
    tbl[1]  = '{1, 1, A_MSIP, 64'h0,                   8'h00, 64'h0,                   1};
    tbl[2]  = '{1, 0, A_MSIP, 64'h0,                   8'h00, 64'h1,                   1};
    tbl[3]  = '{1, 1, A_CMP,  64'h1122_3344_5566_7788, 8'hFF, 64'h0,                   1};
    tbl[4]  = '{1, 1, A_CMP,  64'hFFFF_FFFF_AAAA_AAAA, 8'h0F, 64'h0,                   1};
    tbl[5]  = '{1, 0, A_CMP,  64'h0,                   8'h00, 64'h1122_3344_AAAA_AAAA, 1};
    tbl[6]  = '{1, 0, A_UNM,  64'h0,                   8'h00, 64'h0,                   1};
    tbl[7]  = '{1, 1, A_UNM,  ONES,                    8'hFF, 64'h0,                   1};
    tbl[8]  = '{1, 0, A_SSIP, 64'h0,                   8'h00, 64'h0,                   1};
    tbl[9]  = '{1, 1, A_MSIP, 64'h0,                   8'h01, 64'h0,                   0};
    tbl[10] = '{1, 0, A_MSIP, 64'h0,                   8'h00, 64'h0,                   0};
    tbl[11] = '{1, 1, A_CMP,  ONES,                    8'hFF, 64'h0,                   0};

    // Reset release, 10 idle cycles, then read MTIME
    idle(0);
    do_reset(1'b0, 1'b0, '0, '0, '0);
    idle(10);
    step(1'b1, 1'b0, A_TIME, '0, '0);
    check("first_read_div1", o_rdata[0], 64'd10);
    check("first_read_div4", o_rdata[1], 64'd2);
    check("first_read_mtip", 64'(o_mtip[0]), 64'd0);

    // MTIMECMP = 0x20, poll for MTIP on the DIV=1 instance
    step(1'b1, 1'b1, A_CMP, 64'h20, 8'hFF);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      step(1'b0, 1'b0, '0, '0, '0);
      if (o_mtip[0]) begin
        seen = 1'b1;
        check("mtip_rise_mtime", o_mtime[0], 64'h20);
      end
    end
    check("mtip_rise_seen", 64'(seen), 64'd1);
    step(1'b1, 1'b1, A_CMP, ONES, 8'hFF);
    check("mtip_clear_div1", 64'(o_mtip[0]), 64'd0);
    check("mtip_clear_div4", 64'(o_mtip[1]), 64'd0);

    // MTIME wrap and partial write
    step(1'b1, 1'b1, A_TIME, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF);
    step(1'b1, 1'b0, A_TIME, '0, '0);
    check("wrap_read0", o_rdata[0], 64'hFFFF_FFFF_FFFF_FFFE);
    step(1'b1, 1'b0, A_TIME, '0, '0);
    check("wrap_read1", o_rdata[0], ONES);
    step(1'b1, 1'b0, A_TIME, '0, '0);
    check("wrap_read2", o_rdata[0], 64'h0);
    step(1'b1, 1'b1, A_TIME, 64'h1234_5678_9ABC_DEAB, 8'h01);
    check("partial_div1", o_mtime[0], 64'hAB);
    check("partial_div4", o_mtime[1], 64'hFFFF_FFFF_FFFF_FFAB);

    // Write to MTIME in a DIV=4 tick cycle: written value, no increment
    step(1'b1, 1'b1, A_TIME, 64'h50, 8'hFF);
    idle(3);
    step(1'b1, 1'b1, A_TIME, 64'h100, 8'hFF);
    check("tickwr_div1", o_mtime[0], 64'h100);
    check("tickwr_div4", o_mtime[1], 64'h100);
    step(1'b0, 1'b0, '0, '0, '0);
    check("tickwr_next_div1", o_mtime[0], 64'h101);
    check("tickwr_next_div4", o_mtime[1], 64'h100);

    // Register table
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].v, tbl[i].w, tbl[i].a, tbl[i].wd, tbl[i].wm);
      for (int d = 0; d < 2; d++) begin
        check($sformatf("tbl%0d_rdata[%0d]", i, d), o_rdata[d], tbl[i].exp_rdata);
        check($sformatf("tbl%0d_msip[%0d]", i, d), 64'(o_msip[d]), 64'(tbl[i].exp_msip));
      end
    end

    // SETSSIP pulse
    step(1'b1, 1'b1, A_SSIP, 64'h1, 8'h01);
    check("ssip_pulse", 64'(o_ssip_set[0]), 64'(exp_pulse));
    step(1'b0, 1'b0, '0, '0, '0);
    check("ssip_pulse_end", 64'(o_ssip_set[0]), 64'd0);
    step(1'b1, 1'b1, A_SSIP, 64'h1, 8'h00);
    check("ssip_masked", 64'(o_ssip_set[0]), 64'd0);

    // Reset coinciding with a request
    step(1'b1, 1'b0, A_MSIP, '0, '0);
    do_reset(1'b1, 1'b1, A_SSIP, 64'h1, 8'h01);
    check("rst_rvalid", 64'(o_rvalid[0]), 64'd0);
    check("rst_ssip", 64'(o_ssip_set[0]), 64'd0);

    // Randomised traffic against the model
    addrs[0] = A_MSIP; addrs[1] = A_CMP; addrs[2] = A_TIME;
    addrs[3] = A_SSIP; addrs[4] = A_UNM; addrs[5] = BASE + 64'h7FF0;
    for (int i = 0; i < 400; i++) begin
      step(bit'($urandom_range(0, 4) != 0), bit'($urandom_range(0, 1)),
           addrs[$urandom_range(0, 5)], {$urandom, $urandom}, 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/aclint_memory.md
Name: aclint_memory

Overview:
- Memory-mapped ACLINT slave at MMAP_ACLINT_BEGIN..MMAP_ACLINT_END on the core membus.
- Holds MSIP, MTIMECMP and MTIME. Generates the SETSSIP pulse.
- Drives the interrupt-pending sources consumed by the CSR unit (mip.MSIP, mip.MTIP, mip.SSIP).
- Exports mtime for the TIME CSR.

Parameters:
- BASE, eei::MMAP_ACLINT_BEGIN, absolute base address; register offset = i_addr - BASE.
- MTIME_DIV, 1, mtime increments once every MTIME_DIV clocks; legal range 1..65535.

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  synchronous active-high reset.
- i_valid  input  1  bus request valid.
- o_ready  output  1  bus request accept; tied 1.
- i_addr  input  64  byte address (eei::Addr); 8-byte aligned.
- i_wen  input  1  1 = write, 0 = read.
- i_wdata  input  64  write data.
- i_wmask  input  8  byte-enable mask; bit k enables byte k.
- o_rvalid  output  1  response valid; asserted for both reads and writes.
- o_rdata  output  64  read data; 0 for writes.
- o_msip  output  1  machine software interrupt pending.
- o_mtip  output  1  machine timer interrupt pending.
- o_ssip_set  output  1  one-cycle pulse that sets mip.SSIP in the CSR unit.
- o_mtime  output  64  current mtime, for the TIME CSR.

Behaviour:
- Clocking: one clock domain i_clk. i_rst is synchronous and active-high; every register below clears on the i_clk edge where i_rst=1.
- Reset values: msip=0; mtime=0; mtimecmp=64'hFFFF_FFFF_FFFF_FFFF (no spurious MTIP); prescale counter=0; o_rvalid=0; o_rdata=0; o_ssip_set=0.
- Handshake: a request is accepted when i_valid && o_ready. o_rvalid=1 exactly one cycle after acceptance. Back-to-back requests every cycle are supported. No outstanding-request limit beyond one in flight per cycle.
- Address decode on offset = i_addr - BASE:
  - 0x0000: MSIP. Bit 0 is R/W; other bits read 0. Written only when wmask[0]=1.
  - 0x4000: MTIMECMP, 64-bit R/W.
  - 0x7FF8: MTIME, 64-bit R/W.
  - 0x8000: SETSSIP. Reads 0. A write with wmask[0]=1 and wdata[0]=1 makes o_ssip_set=1 for exactly the next cycle; otherwise no effect.
  - Any other offset: reads 0, writes ignored, o_rvalid still asserted.
- Byte masking: 64-bit registers update only the bytes whose wmask bit is set. Masked-off bytes keep their old value.
- Read data: o_rdata is the register value sampled at the acceptance edge, i.e. the value before any same-cycle increment or write.
- Timer:
  - Prescale counter counts 0..MTIME_DIV-1. mtime += 1 (modulo 2^64) in the cycle the counter is at MTIME_DIV-1; the counter then wraps to 0.
  - With MTIME_DIV=1, mtime increments every cycle.
  - mtime = 64'hFFFF_FFFF_FFFF_FFFF wraps to 0.
- Simultaneous write and increment: a bus write to MTIME wins over the tick. The written bytes take the new data; the unwritten bytes hold (no increment that cycle). The prescale counter is reset to 0 on any MTIME write.
- o_mtip: combinational, = (mtime >= mtimecmp), unsigned 64-bit compare on registered values. A write to MTIMECMP is therefore reflected the cycle after acceptance.
- o_msip = msip register. o_mtime = mtime register.
- Reset mid-operation: an accepted request whose response cycle coincides with i_rst=1 produces o_rvalid=0. A pending o_ssip_set pulse is dropped.

Optional Feature:
- Macro: ACLINT_SSWI_EN.
- Defined: the SETSSIP register at 0x8000 behaves as described; o_ssip_set is driven.
- Undefined: offset 0x8000 decodes as unmapped (reads 0, writes ignored); o_ssip_set tied 0.

Test Plan:
- Reset release, MTIME_DIV=1, idle for 10 cycles, then read 0x200_7FF8 -> o_rvalid one cycle later. o_rdata = cycle count since reset deassertion (10 ± bench offset, checked exactly against a model). o_mtip=0.
- Write MTIMECMP=0x20 (wmask=8'hFF), then poll -> o_mtip rises in the cycle mtime reaches 0x20. Then write MTIMECMP=0xFFFF_FFFF_FFFF_FFFF -> o_mtip=0 the next cycle.
- Write MTIME=0xFFFF_FFFF_FFFF_FFFE with wmask=8'hFF -> reads back 0xFFFF...FFFE/FFFF. After 2 ticks it reads 0 (wrap). Partial write with wmask=8'h01, wdata=0xAB -> only byte 0 changes.
- Write MSIP wdata=1 -> o_msip=1. Write wdata=0 with wmask=0 -> o_msip stays 1. Read MSIP -> o_rdata=1.
- With ACLINT_SSWI_EN, write 0x200_8000 wdata=1 -> o_ssip_set high for exactly one cycle; read 0x8000 -> 0. Without the macro -> o_ssip_set never asserts.
- MTIME_DIV=4 build: mtime increments every 4th cycle. A write to MTIME issued in a tick cycle loads the written value with no increment that cycle. Read of unmapped offset 0x1234 -> o_rvalid=1, o_rdata=0.
